// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 stride-2 FP32 max-pooling stage.
// The optional RELU_FUSE_EN build macro is consumed by maxpool2x2_stream.
package pool_pkg;

    localparam int          FP32_BITS     = 32;
    localparam int          FP32_SIGN_BIT = 31;
    localparam logic [31:0] FP32_ZERO     = 32'h0000_0000;

    typedef logic [FP32_BITS-1:0] fp32_t;

    // Position of the current pixel inside its 2x2 window: {row[0], col[0]}.
    typedef enum logic [1:0] {
        PH_EVEN_EVEN = 2'b00,
        PH_EVEN_ODD  = 2'b01,
        PH_ODD_EVEN  = 2'b10,
        PH_ODD_ODD   = 2'b11
    } phase_e;

    // One pooled partial result is kept per pair of input columns.
    function automatic int linebuf_depth(input int width);
        return width / 2;
    endfunction

    // Counter width able to hold every value 0..limit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/fp32_max.sv
// Combinational FP32 maximum using a sign-magnitude compare.
// Signed zeros compare equal and the first operand is returned on ties.
module fp32_max
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-2:0] a_mag;
    logic [DATA_WIDTH-2:0] b_mag;
    logic                  both_zero;
    logic                  b_wins;

    assign a_neg     = a[FP32_SIGN_BIT];
    assign b_neg     = b[FP32_SIGN_BIT];
    assign a_mag     = a[DATA_WIDTH-2:0];
    assign b_mag     = b[DATA_WIDTH-2:0];
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    // NOTE: every branch of an always_comb must assign its outputs; the default
    // first line guarantees that and keeps the block free of inferred latches.
    always_comb begin
        b_wins = 1'b0;
        if (both_zero) begin
            b_wins = 1'b0;
        end else if (a_neg != b_neg) begin
            b_wins = a_neg;
        end else if (!a_neg) begin
            b_wins = (b_mag > a_mag);
        end else begin
            b_wins = (b_mag < a_mag);
        end
    end

    assign y = b_wins ? b : a;

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 FP32 max pool over a raster-order feature map.
// Define RELU_FUSE_EN to clamp negative (and -0) pooled results to +0.
module maxpool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_done
);

    localparam int LB_DEPTH  = linebuf_depth(WIDTH);
    localparam int LB_SLOTS  = (LB_DEPTH > 0) ? LB_DEPTH : 1;
    localparam int LB_AW     = (LB_SLOTS > 1) ? $clog2(LB_SLOTS) : 1;
    localparam int COL_W     = cnt_width(WIDTH);
    localparam int ROW_W     = cnt_width(HEIGHT);
    localparam int POOL_COLS = 2 * (WIDTH / 2);
    localparam int POOL_ROWS = 2 * (HEIGHT / 2);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] POOL_COL_END = COL_W'(POOL_COLS);
    localparam logic [ROW_W-1:0] POOL_ROW_END = ROW_W'(POOL_ROWS);
    localparam logic [COL_W-1:0] WIN_COL_LAST = COL_W'((POOL_COLS > 0) ? POOL_COLS - 1 : 0);
    localparam logic [ROW_W-1:0] WIN_ROW_LAST = ROW_W'((POOL_ROWS > 0) ? POOL_ROWS - 1 : 0);

    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  frame_done_q, frame_done_d;

    logic [DATA_WIDTH-1:0] linebuf_q [LB_SLOTS];
    logic [LB_AW-1:0]      lb_addr;
    logic [DATA_WIDTH-1:0] lb_rdata;
    logic                  lb_we;

    logic [DATA_WIDTH-1:0] max_row_y;
    logic [DATA_WIDTH-1:0] max_line_y;
    logic                  in_window;
    phase_e                phase;

    function automatic fp32_t relu_clamp(input fp32_t x);
`ifdef RELU_FUSE_EN
        return x[FP32_SIGN_BIT] ? FP32_ZERO : x;
`else
        return x;
`endif
    endfunction

    assign lb_addr   = LB_AW'(col_q >> 1);
    assign lb_rdata  = linebuf_q[lb_addr];
    assign in_window = (col_q < POOL_COL_END) && (row_q < POOL_ROW_END);
    assign phase     = phase_e'({row_q[0], col_q[0]});

    // Horizontal pair reduction: left pixel (held) against the right pixel.
    fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_row (
        .a (hold_q),
        .b (data_in),
        .y (max_row_y)
    );

    // Vertical reduction: upper-row pair result against the lower-left pixel.
    fp32_max #(.DATA_WIDTH(DATA_WIDTH)) u_max_line (
        .a (lb_rdata),
        .b (data_in),
        .y (max_line_y)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (valid_in) begin
            if (in_window) begin
                unique case (phase)
                    PH_EVEN_EVEN: hold_d = data_in;
                    PH_EVEN_ODD:  lb_we  = 1'b1;
                    PH_ODD_EVEN:  hold_d = max_line_y;
                    PH_ODD_ODD: begin
                        data_out_d   = relu_clamp(max_row_y);
                        valid_out_d  = 1'b1;
                        frame_done_d = (row_q == WIN_ROW_LAST) && (col_q == WIN_COL_LAST);
                    end
                    default: ;
                endcase
            end

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge value of the others, matching real register behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset; every entry is written on
    // the even row before the odd row reads it, and a reset port would stop it
    // mapping onto distributed RAM.
    always_ff @(posedge clk) begin
        if (lb_we && !rst) begin
            linebuf_q[lb_addr] <= max_row_y;
        end
    end

    assign valid_out  = valid_out_q;
    assign data_out   = data_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: four instances of different frame
// sizes, directed scenarios plus random streams checked against a frame model.
module tb_maxpool2x2_stream;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vin   [NDUT];
    logic [31:0] din   [NDUT];
    logic        vout  [NDUT];
    logic [31:0] dout  [NDUT];
    logic        fdone [NDUT];

    int dim_w [NDUT] = '{4, 2, 5, 7};
    int dim_h [NDUT] = '{2, 2, 2, 5};

    // Reference model state
    int          m_col [NDUT];
    int          m_row [NDUT];
    logic [31:0] pix   [NDUT][8][8];
    logic        exp_v [NDUT];
    logic        exp_fd[NDUT];
    logic [31:0] exp_d [NDUT];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid [NDUT] = '{0, 0, 0, 0};
    int n_fd    [NDUT] = '{0, 0, 0, 0};
    logic saw_col4 = 1'b0;

    logic [31:0] basic [8] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
                               32'h40400000, 32'hC0000000, 32'hBF800000, 32'hC0000000};
    logic [31:0] negw  [4] = '{32'hBF800000, 32'hC0000000, 32'hC0000000, 32'hC0400000};
    logic [31:0] zerow [4] = '{32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000};
    logic [31:0] odd5  [10] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000, 32'h47000000,
                                32'h40400000, 32'hC0000000, 32'hBF800000, 32'hC0000000, 32'h47000000};

    always #5 clk = ~clk;

    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(4), .HEIGHT(2)) u_dut_4x2 (
        .clk(clk), .rst(rst), .valid_in(vin[0]), .data_in(din[0]),
        .valid_out(vout[0]), .data_out(dout[0]), .frame_done(fdone[0]));
    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(2), .HEIGHT(2)) u_dut_2x2 (
        .clk(clk), .rst(rst), .valid_in(vin[1]), .data_in(din[1]),
        .valid_out(vout[1]), .data_out(dout[1]), .frame_done(fdone[1]));
    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(5), .HEIGHT(2)) u_dut_5x2 (
        .clk(clk), .rst(rst), .valid_in(vin[2]), .data_in(din[2]),
        .valid_out(vout[2]), .data_out(dout[2]), .frame_done(fdone[2]));
    maxpool2x2_stream #(.DATA_WIDTH(32), .WIDTH(7), .HEIGHT(5)) u_dut_7x5 (
        .clk(clk), .rst(rst), .valid_in(vin[3]), .data_in(din[3]),
        .valid_out(vout[3]), .data_out(dout[3]), .frame_done(fdone[3]));

    always @(negedge clk) begin
        for (int j = 0; j < NDUT; j++) begin
            if (vout[j] === 1'b1) n_valid[j]++;
            if (fdone[j] === 1'b1) n_fd[j]++;
        end
        if (vout[2] === 1'b1 && dout[2] === 32'h47000000) saw_col4 = 1'b1;
    end

    // Real-number ordering of an FP32 word; -0 and +0 map to the same key.
    function automatic longint fkey(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] x);
`ifdef RELU_FUSE_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input int k, input logic [31:0] d);
        int r, c, pw, ph;
        logic [31:0] m;
        r  = m_row[k];
        c  = m_col[k];
        pw = 2 * (dim_w[k] / 2);
        ph = 2 * (dim_h[k] / 2);
        pix[k][r][c] = d;
        if (r < ph && c < pw && (r % 2) == 1 && (c % 2) == 1) begin
            m = fmax(fmax(fmax(pix[k][r-1][c-1], pix[k][r-1][c]), pix[k][r][c-1]), d);
            exp_v[k]  = 1'b1;
            exp_d[k]  = relu(m);
            exp_fd[k] = (r == ph - 1) && (c == pw - 1);
        end
        c++;
        if (c == dim_w[k]) begin
            c = 0;
            r++;
            if (r == dim_h[k]) r = 0;
        end
        m_row[k] = r;
        m_col[k] = c;
    endtask

    task automatic check_all();
        for (int j = 0; j < NDUT; j++) begin
            check($sformatf("valid_out[%0d]@%0d", j, cyc), {31'b0, vout[j]}, {31'b0, exp_v[j]});
            check($sformatf("frame_done[%0d]@%0d", j, cyc), {31'b0, fdone[j]}, {31'b0, exp_fd[j]});
            check($sformatf("data_out[%0d]@%0d", j, cyc), dout[j], exp_d[j]);
        end
    endtask

    // One clock: drive (k < 0 means no DUT gets a pixel), update model, check.
    task automatic cycle(input int k, input logic v, input logic [31:0] d, input logic r);
        rst = r;
        for (int j = 0; j < NDUT; j++) begin
            vin[j]    = 1'b0;
            exp_v[j]  = 1'b0;
            exp_fd[j] = 1'b0;
        end
        if (k >= 0) begin
            vin[k] = v;
            din[k] = d;
        end
        if (r) begin
            for (int j = 0; j < NDUT; j++) begin
                m_col[j] = 0;
                m_row[j] = 0;
                exp_d[j] = 32'h0;
            end
        end else if (k >= 0 && v) begin
            model_accept(k, d);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(-1, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic [31:0] rand_pix();
        logic [31:0] d;
        d = $urandom;
        if (d[30:23] == 8'hFF) d[30] = 1'b0;
        if ($urandom_range(7) == 0) d = {d[31], 31'b0};
        return d;
    endfunction

    initial begin
        int base_v, base_f, sent;
        for (int j = 0; j < NDUT; j++) din[j] = 32'h0;

        // Reset, with a pixel offered during reset that must be ignored
        cycle(-1, 1'b0, 32'h0, 1'b1);
        cycle(0, 1'b1, 32'h40800000, 1'b1);
        idle(1);

        // Basic window on 4x2
        base_v = n_valid[0]; base_f = n_fd[0];
        for (int i = 0; i < 8; i++) cycle(0, 1'b1, basic[i], 1'b0);
        idle(2);
        check("basic pulses", n_valid[0] - base_v, 2);
        check("basic frame_done", n_fd[0] - base_f, 1);
        check("basic last data", dout[0], 32'h3F000000);

        // Same frame with valid_in low every other cycle
        base_v = n_valid[0];
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1'b1, basic[i], 1'b0);
            idle(1);
        end
        idle(1);
        check("gapped pulses", n_valid[0] - base_v, 2);

        // All-negative window on 2x2
        for (int i = 0; i < 4; i++) cycle(1, 1'b1, negw[i], 1'b0);
        idle(1);
`ifdef RELU_FUSE_EN
        check("all-negative", dout[1], 32'h00000000);
`else
        check("all-negative", dout[1], 32'hBF800000);
`endif

        // Odd width: column 4 consumed but never pooled
        base_v = n_valid[2];
        for (int i = 0; i < 10; i++) cycle(2, 1'b1, odd5[i], 1'b0);
        idle(2);
        check("odd width pulses", n_valid[2] - base_v, 2);
        check("odd width col4 seen", {31'b0, saw_col4}, 32'h0);

        // Reset mid-frame, then a full frame
        for (int i = 0; i < 3; i++) cycle(0, 1'b1, 32'h40800000, 1'b0);
        cycle(0, 1'b1, 32'h40800000, 1'b1);
        base_v = n_valid[0];
        for (int i = 0; i < 8; i++) cycle(0, 1'b1, basic[i], 1'b0);
        idle(2);
        check("post-reset pulses", n_valid[0] - base_v, 2);
        check("post-reset last data", dout[0], 32'h3F000000);

        // Back-to-back frames on 2x2, second one all signed zeros
        base_f = n_fd[1];
        for (int i = 0; i < 4; i++) cycle(1, 1'b1, negw[i], 1'b0);
        for (int i = 0; i < 4; i++) cycle(1, 1'b1, zerow[i], 1'b0);
        idle(2);
        check("b2b frame_done", n_fd[1] - base_f, 2);
`ifdef RELU_FUSE_EN
        check("signed zero", dout[1], 32'h00000000);
`else
        check("signed zero", dout[1], 32'h80000000);
`endif

        // Random back-to-back frames on 4x2, no gaps
        base_f = n_fd[0];
        for (int i = 0; i < 24; i++) cycle(0, 1'b1, rand_pix(), 1'b0);
        idle(2);
        check("random 4x2 frame_done", n_fd[0] - base_f, 3);

        // Random gapped frames on 7x5 (odd width and height)
        base_f = n_fd[3];
        sent = 0;
        while (sent < 3 * 35) begin
            if ($urandom_range(3) != 0) begin
                cycle(3, 1'b1, rand_pix(), 1'b0);
                sent++;
            end else begin
                idle(1);
            end
        end
        idle(2);
        check("random 7x5 frame_done", n_fd[3] - base_f, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Stage directly downstream of one featuremap conv2d filter block (16-channel conv + bias adder).
- Consumes that block's raster-order FP32 output stream (data_out/valid_out) for one output channel.
- Performs 2x2, stride-2 max pooling and emits the pooled stream to the next layer's input FIFO.
- One instance per filter; no backpressure, matching the upstream producer.

Parameters:
- DATA_WIDTH, 32, word width; IEEE-754 single precision; only 32 is supported.
- WIDTH, 56, input row length in pixels, unpadded.
- HEIGHT, 56, input rows per frame.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in is a valid pixel this cycle; connects to the conv block's valid_out.
- data_in  input  DATA_WIDTH  FP32 pixel in raster order.
- valid_out  output  1  one-cycle pulse per pooled result.
- data_out  output  DATA_WIDTH  pooled FP32 result.
- frame_done  output  1  one-cycle pulse with the last pooled output of a frame.

Behaviour:
- Reset: valid_out=0, data_out=0, frame_done=0, col=0, row=0, hold=0. Line buffer contents are don't-care.
- Clock and reset: one clock (clk); reset rst is synchronous and active-high. While rst=1, valid_in is ignored.
- Counters advance only on cycles with valid_in=1:
  - col counts 0..WIDTH-1. At WIDTH-1 it wraps to 0 and row increments.
  - row counts 0..HEIGHT-1. At HEIGHT-1 with col=WIDTH-1 it wraps to 0 (frame end).
- Pooling windows cover col<2*(WIDTH/2) and row<2*(HEIGHT/2). Pixels outside this range are consumed but ignored (odd WIDTH or HEIGHT drops the last column or row).
- Even row:
  - col even: hold <= data_in.
  - col odd: linebuf[col>>1] <= max(hold, data_in).
- Odd row:
  - col even: hold <= max(linebuf[col>>1], data_in).
  - col odd: data_out <= max(hold, data_in); valid_out=1 on the next cycle.
- Latency: exactly 1 cycle from the accepting edge of the window's last pixel to valid_out. No stalls. Gaps in valid_in of any length are tolerated.
- Output hold: when valid_out=0, data_out keeps its last value.
- frame_done: asserted in the same cycle as the valid_out of the last window (row 2*(HEIGHT/2)-1, col 2*(WIDTH/2)-1). If HEIGHT/2=0 or WIDTH/2=0, it is never asserted.
- Back-to-back frames: the first pixel of the next frame may arrive the cycle after the last pixel. No bubble is required.
- FP32 max (sign-magnitude compare):
  - Different signs: the positive operand wins.
  - Both positive: the larger magnitude wins.
  - Both negative: the smaller magnitude wins.
  - +0 vs -0: treated as equal; the first operand is returned.
  - NaN/Inf: not produced upstream; result is unspecified but deterministic.
- Reset mid-frame: counters return to 0, partial windows are discarded, no valid_out is produced for them. The next accepted pixel is treated as (row 0, col 0).
- Line buffer: WIDTH/2 entries × DATA_WIDTH, single read and single write port. Inferable as registers or distributed RAM.

Optional Feature:
- Macro RELU_FUSE_EN.
- Defined: the registered result is clamped. If the selected max has sign bit 1 (any negative or -0), data_out=32'h00000000. This is equivalent to ReLU before pooling.
- Undefined: raw max is output, negatives pass through. Latency is identical in both builds.

Decomposition:
- Package pool_pkg:
  - FP32_ZERO constant (32'h0).
  - FP32_SIGN_BIT index (31).
  - Typedef for the FP32 word.
  - Function computing the line-buffer depth (WIDTH/2).
- Sub-module fp32_max: combinational, two DATA_WIDTH inputs, one output, implements the compare rules above. It is instantiated twice (even-row and odd-row paths).

Test Plan:
- Basic window: WIDTH=4, HEIGHT=2.
  - Stimulus: row0 = 3F800000, 40000000, 3F000000, BF800000; row1 = 40400000, C0000000, BF800000, C0000000.
  - Required: exactly 2 valid_out pulses, data 40400000 then 3F000000. frame_done coincides with the second pulse.
- All-negative window: WIDTH=2, HEIGHT=2, inputs BF800000, C0000000, C0000000, C0400000.
  - Required: BF800000 without RELU_FUSE_EN; 00000000 with it.
- Gapped input: the basic-window stimulus with valid_in low on every other cycle.
  - Required: identical 2 outputs, each 1 cycle after its 4th window pixel.
- Odd width: WIDTH=5, HEIGHT=2, column 4 values = 47000000.
  - Required: 2 outputs only, 47000000 never appears.
- Reset mid-frame: 3 pixels of 40800000, then rst for 1 cycle, then the basic-window frame.
  - Required: no valid_out during or after reset until the correct frame results 40400000, 3F000000.
- Back-to-back frames and signed zero: two frames streamed without a gap.
  - Required: two frame_done pulses and correct per-frame outputs.
  - A window of 80000000, 00000000, 80000000, 80000000 yields sign-bit-agnostic zero (exact value checked per the first-operand rule).
